// File: rtl/dump_cntrl.sv
// Channel RAM dump sequencer: after capture, streams ENTRIES bytes oldest-first to the UART,
// one read / latch / send / wait-for-tx_done round trip per byte.
module dump_cntrl #(
   parameter int unsigned ENTRIES = 384,
   parameter int unsigned LOG2    = 9
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            dump_start,
   input  logic [2:0]      dump_chan,
   input  logic            dump_abort,
   input  logic            capture_done,
   input  logic [LOG2-1:0] waddr,
   input  logic [7:0]      rdata,
   input  logic            tx_done,
   output logic [LOG2-1:0] raddr,
   output logic            re,
   output logic [2:0]      ram_sel,
   output logic [7:0]      tx_data,
   output logic            trmt,
   output logic            busy,
   output logic            dump_done,
   output logic            dump_err
);

   typedef enum logic [2:0] {StIdle, StRead, StLatch, StSend, StWaitTx, StDone} state_e;

   localparam logic [LOG2-1:0] LastAddr = LOG2'(ENTRIES - 1);
   localparam logic [LOG2:0]   LastCnt  = (LOG2 + 1)'(ENTRIES - 1);

   state_e        state;
   logic [LOG2:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= StIdle;
         cnt       <= '0;
         raddr     <= '0;
         re        <= 1'b0;
         ram_sel   <= 3'd0;
         tx_data   <= 8'h00;
         trmt      <= 1'b0;
         busy      <= 1'b0;
         dump_done <= 1'b0;
         dump_err  <= 1'b0;
      end else begin
         // Pulse outputs default low; each is raised on entry to the state that owns it.
         re        <= 1'b0;
         trmt      <= 1'b0;
         dump_done <= 1'b0;
         dump_err  <= 1'b0;
         if (busy && dump_abort) begin
            state <= StIdle;
            busy  <= 1'b0;
         end else begin
            case (state)
               StIdle: begin
                  if (dump_start) begin
                     if (capture_done && (dump_chan <= 3'd4)) begin
                        ram_sel <= dump_chan;
                        raddr   <= waddr;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        re      <= 1'b1;
                        state   <= StRead;
                     end else begin
                        dump_err <= 1'b1;
                     end
                  end
               end
               StRead: state <= StLatch;
               StLatch: begin
                  tx_data <= rdata;
                  trmt    <= 1'b1;
                  state   <= StSend;
               end
               StSend: state <= StWaitTx;
               StWaitTx: begin
                  if (tx_done) begin
                     cnt   <= cnt + 1'b1;
                     raddr <= (raddr == LastAddr) ? '0 : raddr + 1'b1;
                     if (cnt == LastCnt) begin
                        dump_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StDone;
                     end else begin
                        re    <= 1'b1;
                        state <= StRead;
                     end
                  end
               end
               StDone: state <= StIdle;
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule
